wb_initiator: RTL
=================

# wb_initiator

Wishbone classic single-transfer initiator (bus master) converting a valid/ready request/response port into Wishbone cycles toward memory-mapped peripherals such as the timer and other responders. Issues one transfer at a time, waits for ack or err, enforces a bus timeout, and returns read data plus status on a buffered response port.

## Interface
- WB_DATA_WIDTH, 32, data bus width; must be a multiple of 8
- WB_ADDR_WIDTH, 32, address bus width
- TIMEOUT_CYCLES, 255, maximum cycles cyc/stb held without ack/err; 0 disables the timeout
- clk_i  in  1  single clock, all logic on rising edge
- rst_ni  in  1  synchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  initiator idle, request accepted on valid&ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  WB_ADDR_WIDTH  byte address
- req_data_i  in  WB_DATA_WIDTH  write data
- req_sel_i  in  WB_DATA_WIDTH/8  byte lane select
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed on valid&ready
- rsp_data_o  out  WB_DATA_WIDTH  read data (0 for writes, errors, timeouts)
- rsp_err_o  out  1  transfer ended by wb_err_i or timeout
- rsp_timeout_o  out  1  transfer ended by timeout
- wb_cyc_o, wb_stb_o  out  1 each  cycle/strobe, always equal
- wb_we_o  out  1  write enable
- wb_adr_o  out  WB_ADDR_WIDTH  address
- wb_dat_o  out  WB_DATA_WIDTH  write data
- wb_sel_o  out  WB_DATA_WIDTH/8  byte select
- wb_dat_i  in  WB_DATA_WIDTH  read data
- wb_ack_i, wb_err_i  in  1 each  termination from responder

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: req_ready_o=1. On req_valid_i: latch we/addr/data/sel into Wishbone output registers, clear timeout counter, go BUS.
- BUS: wb_cyc_o=wb_stb_o=1, address/data/sel/we stable. Priority per cycle: wb_err_i > wb_ack_i > timeout.
  - err: rsp_err_o=1, rsp_data_o=0, go RESP.
  - ack: rsp_err_o=0; read -> rsp_data_o=wb_dat_i sampled that cycle; write -> rsp_data_o=0; go RESP.
  - no termination and counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): rsp_err_o=1, rsp_timeout_o=1, rsp_data_o=0, go RESP. Otherwise counter+1.
- RESP: rsp_valid_o=1, response fields stable until rsp_ready_i; then go IDLE, clear response fields.
- wb_ack_i/wb_err_i outside BUS are ignored.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset (rst_ni=0 at a rising edge): state IDLE; req_ready_o=1; rsp_valid_o, rsp_err_o, rsp_timeout_o, wb_cyc_o, wb_stb_o, wb_we_o =0; rsp_data_o, wb_adr_o, wb_dat_o, wb_sel_o =0. Reset mid-transfer drops cyc/stb at that edge; pending response discarded.
- Request handshake at edge N -> cyc/stb high from N+1.
- Termination sampled at edge M -> cyc/stb low and rsp_valid_o high from M+1 (single-cycle termination holds cyc for exactly one cycle).
- rsp handshake at edge K -> req_ready_o high from K+1. Minimum 3 cycles per transfer.
- Timeout: cyc/stb asserted for exactly TIMEOUT_CYCLES cycles before abort; ack on the final cycle wins over timeout.
- Counter width $clog2(TIMEOUT_CYCLES+1); never wraps.

## Structure
- Shared package wb_pkg: FSM state enum (IDLE/BUS/RESP), default width constants, response status bit positions.
- One sub-module: wb_initiator_timeout (counter with clear, enable, expire output; parameter TIMEOUT_CYCLES, TIMEOUT_CYCLES=0 -> expire tied 0).

## Test plan
- Reset: hold rst_ni=0 two cycles during an active BUS state -> next cycle cyc=0, rsp_valid=0, req_ready=1, all data outputs 0.
- Write 0xDEADBEEF to 0x00000004, sel=0xF, ack 2 cycles after cyc -> cyc high 3 cycles, wb_dat_o=0xDEADBEEF, rsp_valid with err=0, data=0.
- Read 0x00000008, responder acks in first cycle with 0x12345678 -> rsp_data_o=0x12345678 one cycle later; rsp_ready held low 5 cycles -> response stable, req_ready=0 throughout.
- Simultaneous ack and err -> rsp_err=1, rsp_timeout=0, rsp_data=0.
- TIMEOUT_CYCLES=4, no responder -> cyc high exactly 4 cycles, then rsp_err=1, rsp_timeout=1; repeat with ack on 4th cycle -> err=0.
- Back-to-back requests with rsp_ready=1 constant -> one transfer every 3 cycles, stray ack in IDLE ignored.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared state encoding, default widths and response status bit positions.
package wb_pkg;
   typedef enum logic [1:0] {IDLE, BUS, RESP} wb_state_e;
   localparam int WB_DEF_DATA_WIDTH = 32;
   localparam int WB_DEF_ADDR_WIDTH = 32;
   localparam int WB_DEF_TIMEOUT    = 255;
   localparam int RSP_ERR_BIT       = 0;
   localparam int RSP_TIMEOUT_BIT   = 1;
   localparam int RSP_STATUS_W      = 2;
endpackage

// File: rtl/wb_initiator_timeout.sv
// wb_initiator_timeout: saturating bus-cycle counter flagging the last allowed cycle.
module wb_initiator_timeout
   import wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = WB_DEF_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != LAST) ? cnt_q + CW'(1) : cnt_q;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   // A zero budget keeps the counter harmlessly parked and never expires.
   assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LAST);
endmodule

// File: rtl/wb_initiator.sv
// wb_initiator: valid/ready request port to Wishbone classic single transfers with timeout.
module wb_initiator
   import wb_pkg::*;
#(
   parameter int WB_DATA_WIDTH  = WB_DEF_DATA_WIDTH,
   parameter int WB_ADDR_WIDTH  = WB_DEF_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = WB_DEF_TIMEOUT
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic                       req_we_i,
   input  logic [WB_ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [WB_DATA_WIDTH-1:0]   req_data_i,
   input  logic [WB_DATA_WIDTH/8-1:0] req_sel_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [WB_DATA_WIDTH-1:0]   rsp_data_o,
   output logic                       rsp_err_o,
   output logic                       rsp_timeout_o,
   output logic                       wb_cyc_o,
   output logic                       wb_stb_o,
   output logic                       wb_we_o,
   output logic [WB_ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [WB_DATA_WIDTH-1:0]   wb_dat_o,
   output logic [WB_DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic [WB_DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                       wb_ack_i,
   input  logic                       wb_err_i
);
   localparam int SW = WB_DATA_WIDTH / 8;
   wb_state_e               state_q, state_d;
   logic                    we_q, we_d;
   logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [WB_DATA_WIDTH-1:0] dat_q, dat_d, rdata_q, rdata_d;
   logic [SW-1:0]           sel_q, sel_d;
   logic [RSP_STATUS_W-1:0] status_q, status_d;
   logic                    accept, expire;
   assign accept = (state_q == IDLE) && req_valid_i;
   wb_initiator_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (accept),
      .en_i     (state_q == BUS),
      .expire_o (expire)
   );
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      sel_d    = sel_q;
      rdata_d  = rdata_q;
      status_d = status_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            state_d = BUS;
            we_d    = req_we_i;
            adr_d   = req_addr_i;
            dat_d   = req_data_i;
            sel_d   = req_sel_i;
         end
         // err outranks ack, and any termination outranks the timeout
         BUS: if (wb_err_i) begin
            state_d               = RESP;
            rdata_d               = '0;
            status_d              = '0;
            status_d[RSP_ERR_BIT] = 1'b1;
         end else if (wb_ack_i) begin
            state_d  = RESP;
            rdata_d  = we_q ? '0 : wb_dat_i;
            status_d = '0;
         end else if (expire) begin
            state_d                   = RESP;
            rdata_d                   = '0;
            status_d                  = '0;
            status_d[RSP_ERR_BIT]     = 1'b1;
            status_d[RSP_TIMEOUT_BIT] = 1'b1;
         end
         RESP: if (rsp_ready_i) begin
            state_d  = IDLE;
            rdata_d  = '0;
            status_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         rdata_q  <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
      end
   end
   assign req_ready_o   = state_q == IDLE;
   assign rsp_valid_o   = state_q == RESP;
   assign wb_cyc_o      = state_q == BUS;
   assign wb_stb_o      = state_q == BUS;
   assign wb_we_o       = we_q;
   assign wb_adr_o      = adr_q;
   assign wb_dat_o      = dat_q;
   assign wb_sel_o      = sel_q;
   assign rsp_data_o    = rdata_q;
   assign rsp_err_o     = status_q[RSP_ERR_BIT];
   assign rsp_timeout_o = status_q[RSP_TIMEOUT_BIT];
endmodule
